// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Hazard unit for a 5-stage pipeline: memory-wait, branch flush,
//               multi-cycle EX op and load-use stalls, plus a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       source_reg1_id,
    input  logic [4:0]       source_reg2_id,
    input  logic [4:0]       reg_dest_ex,
    input  logic             load_ex,
    input  logic             pc_src_ex,
    input  logic             md_start_ex,
    input  logic             mem_req_mem,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_count
);

    // First EX cycle of a multi-cycle op is spent in RUN, the last one pulses md_done.
    localparam logic [3:0] c_MD_INIT = 4'(MD_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MD_BUSY  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_md_cnt;
    logic [3:0]         w_md_cnt_next;
    logic [CNT_W-1:0]   r_stall_count;
    logic               w_load_use;

    assign w_load_use = load_ex && (reg_dest_ex != 5'd0) &&
                        ((source_reg1_id == reg_dest_ex) || (source_reg2_id == reg_dest_ex));

    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        md_done = 1'b0;

        if (!rst_n) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mem_req_mem && !mem_ready) begin
                        {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
                        w_state_next = ST_MEM_WAIT;
                    end else if (pc_src_ex) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (md_start_ex) begin
                        {stall_f, stall_d, stall_e, flush_m} = 4'b1111;
                        w_md_cnt_next = c_MD_INIT;
                        w_state_next  = ST_MD_BUSY;
                    end else if (w_load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ready) begin
                        {stall_f, stall_d, stall_e, stall_m, flush_w} = 5'b11111;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_MD_BUSY: begin
                    if (r_md_cnt != 4'd0) begin
                        {stall_f, stall_d, stall_e, flush_m} = 4'b1111;
                        w_md_cnt_next = r_md_cnt - 4'd1;
                    end else begin
                        md_done      = 1'b1;
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_md_cnt      <= 4'd0;
            r_stall_count <= '0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
            // Saturate rather than wrap so long runs still read as "very many".
            if (stall_f && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    localparam int c_MD = 4;

    logic        clk;
    logic        rst_n;
    logic [4:0]  source_reg1_id, source_reg2_id, reg_dest_ex;
    logic        load_ex, pc_src_ex, md_start_ex, mem_req_mem, mem_ready;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_m, flush_w, md_done;
    logic [15:0] stall_count;
    logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m;
    logic        s_flush_d, s_flush_e, s_flush_m, s_flush_w, s_md_done;
    logic [3:0]  s_stall_count;

    int n_total = 0;
    int n_bad   = 0;
    int n_md    = 0;

    // Model state: cycles already spent by an active multi-cycle op, memory wait flag,
    // and the number of stalled cycles since reset.
    int md_phase    = 0;
    bit mem_waiting = 0;
    int cnt         = 0;

    pipeline_stall_controller #(.MD_CYCLES(c_MD), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .source_reg1_id(source_reg1_id), .source_reg2_id(source_reg2_id),
        .reg_dest_ex(reg_dest_ex), .load_ex(load_ex), .pc_src_ex(pc_src_ex),
        .md_start_ex(md_start_ex), .mem_req_mem(mem_req_mem), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .md_done(md_done), .stall_count(stall_count)
    );

    pipeline_stall_controller #(.MD_CYCLES(c_MD), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .source_reg1_id(source_reg1_id), .source_reg2_id(source_reg2_id),
        .reg_dest_ex(reg_dest_ex), .load_ex(load_ex), .pc_src_ex(pc_src_ex),
        .md_start_ex(md_start_ex), .mem_req_mem(mem_req_mem), .mem_ready(mem_ready),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m),
        .flush_d(s_flush_d), .flush_e(s_flush_e), .flush_m(s_flush_m), .flush_w(s_flush_w),
        .md_done(s_md_done), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [4:0] s1, s2, rd;
        logic       ld, pc, md, mreq, mrdy;
        logic [8:0] exp;   // {sf, sd, se, sm, fd, fe, fm, fw, md_done}
    } vec_t;

    vec_t tv[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] model_out();
        bit lu;
        lu = load_ex && reg_dest_ex != 0 &&
             (source_reg1_id == reg_dest_ex || source_reg2_id == reg_dest_ex);
        if (!rst_n)               return 9'b000011110;
        if (md_phase > 0)         return (md_phase + 1 < c_MD) ? 9'b111000100 : 9'b000000001;
        if (mem_waiting)          return mem_ready ? 9'b000000000 : 9'b111100010;
        if (mem_req_mem && !mem_ready) return 9'b111100010;
        if (pc_src_ex)            return 9'b000011000;
        if (md_start_ex)          return 9'b111000100;
        if (lu)                   return 9'b110001000;
        return 9'b000000000;
    endfunction

    task automatic model_update(input logic [8:0] exp);
        if (!rst_n) begin
            md_phase = 0; mem_waiting = 0; cnt = 0;
        end else begin
            if (exp[8]) cnt++;
            if (md_phase > 0)      md_phase = (md_phase + 1 >= c_MD) ? 0 : md_phase + 1;
            else if (mem_waiting)  mem_waiting = !mem_ready;
            else if (mem_req_mem && !mem_ready) mem_waiting = 1;
            else if (!pc_src_ex && md_start_ex) md_phase = 1;
        end
    endtask

    task automatic cycle(input bit use_tbl, input logic [8:0] tbl_exp);
        logic [8:0] exp, act, act_s;
        @(negedge clk);
        exp   = model_out();
        act   = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w, md_done};
        act_s = {s_stall_f, s_stall_d, s_stall_e, s_stall_m,
                 s_flush_d, s_flush_e, s_flush_m, s_flush_w, s_md_done};
        check("outputs", 32'(act), 32'(exp));
        check("sat_outputs", 32'(act_s), 32'(exp));
        check("stall_count", 32'(stall_count), 32'(cnt));
        check("stall_count_sat", 32'(s_stall_count), (cnt > 15) ? 32'd15 : 32'(cnt));
        if (use_tbl) check("table", 32'(act), 32'(tbl_exp));
        if (md_done) n_md++;
        @(posedge clk);
        model_update(exp);
        #1;
    endtask

    task automatic set_idle();
        source_reg1_id = 0; source_reg2_id = 0; reg_dest_ex = 0;
        load_ex = 0; pc_src_ex = 0; md_start_ex = 0; mem_req_mem = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; set_idle();
        cycle(0, '0);
        rst_n = 1; n_md = 0;
    endtask

    initial begin
        //          rst  s1  s2  rd  ld pc md mq mr  expected
        tv[0]  = '{1'b1, 0,  5,  5,  1, 0, 0, 0, 0, 9'b110001000}; // load-use on src2
        tv[1]  = '{1'b1, 0,  0,  0,  1, 0, 0, 0, 0, 9'b000000000}; // x0 never stalls
        tv[2]  = '{1'b1, 7,  1,  7,  1, 0, 0, 0, 0, 9'b110001000}; // load-use on src1
        tv[3]  = '{1'b1, 3,  4,  7,  1, 0, 0, 0, 0, 9'b000000000}; // load, no match
        tv[4]  = '{1'b1, 7,  7,  7,  0, 0, 0, 0, 0, 9'b000000000}; // match, not a load
        tv[5]  = '{1'b1, 0,  5,  5,  1, 1, 0, 0, 0, 9'b000011000}; // branch beats load-use
        tv[6]  = '{1'b1, 0,  0,  0,  0, 1, 1, 0, 0, 9'b000011000}; // branch beats md start
        tv[7]  = '{1'b1, 0,  0,  0,  0, 0, 1, 0, 0, 9'b111000100}; // md start
        tv[8]  = '{1'b1, 5,  5,  5,  1, 1, 1, 1, 0, 9'b111100010}; // memory wait wins all
        tv[9]  = '{1'b1, 5,  0,  5,  1, 0, 0, 1, 1, 9'b110001000}; // ready memory: load-use
        tv[10] = '{1'b0, 5,  5,  5,  1, 1, 1, 1, 0, 9'b000011110}; // reset overrides

        rst_n = 0; set_idle();
        cycle(0, '0);
        cycle(0, '0);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            rst_n = tv[i].rst_n;
            source_reg1_id = tv[i].s1; source_reg2_id = tv[i].s2; reg_dest_ex = tv[i].rd;
            load_ex = tv[i].ld; pc_src_ex = tv[i].pc; md_start_ex = tv[i].md;
            mem_req_mem = tv[i].mreq; mem_ready = tv[i].mrdy;
            cycle(1, tv[i].exp);
        end

        // Load-use then x0 destination
        do_reset();
        load_ex = 1; reg_dest_ex = 5; source_reg2_id = 5;
        cycle(0, '0);
        set_idle(); cycle(0, '0);
        check("lu_count", 32'(stall_count), 32'd1);
        load_ex = 1; reg_dest_ex = 0; source_reg2_id = 0;
        cycle(0, '0);
        set_idle(); cycle(0, '0);
        check("x0_count", 32'(stall_count), 32'd1);

        // Branch and load-use in the same cycle
        do_reset();
        pc_src_ex = 1; load_ex = 1; reg_dest_ex = 5; source_reg2_id = 5;
        cycle(0, '0);
        set_idle(); cycle(0, '0);
        check("br_lu_count", 32'(stall_count), 32'd0);

        // Multi-cycle op held in EX for its whole duration
        do_reset();
        md_start_ex = 1;
        repeat (c_MD) cycle(0, '0);
        md_start_ex = 0; cycle(0, '0);
        check("md_count", 32'(stall_count), 32'(c_MD - 1));
        check("md_pulses", 32'(n_md), 32'd1);

        // Memory wait with a pending multi-cycle op behind it
        do_reset();
        mem_req_mem = 1; mem_ready = 0; md_start_ex = 1;
        repeat (3) cycle(0, '0);
        mem_ready = 1; cycle(0, '0);
        mem_req_mem = 0;
        repeat (c_MD) cycle(0, '0);
        md_start_ex = 0; cycle(0, '0);
        check("mem_md_count", 32'(stall_count), 32'(3 + c_MD - 1));
        check("mem_md_pulses", 32'(n_md), 32'd1);

        // Reset in the middle of a multi-cycle op
        do_reset();
        md_start_ex = 1;
        cycle(0, '0);
        cycle(0, '0);
        rst_n = 0;
        cycle(0, '0);
        cycle(0, '0);
        rst_n = 1; md_start_ex = 0;
        repeat (5) cycle(0, '0);
        check("abort_pulses", 32'(n_md), 32'd0);
        check("abort_count", 32'(stall_count), 32'd0);

        // Long memory wait saturates the narrow counter
        do_reset();
        mem_req_mem = 1; mem_ready = 0;
        repeat (20) cycle(0, '0);
        check("long_wait_count", 32'(stall_count), 32'd20);
        check("sat_count", 32'(s_stall_count), 32'd15);
        mem_ready = 1; cycle(0, '0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            source_reg1_id = 5'($urandom_range(0, 3));
            source_reg2_id = 5'($urandom_range(0, 3));
            reg_dest_ex    = 5'($urandom_range(0, 3));
            load_ex        = ($urandom_range(0, 1) == 1);
            pc_src_ex      = ($urandom_range(0, 99) < 15);
            md_start_ex    = ($urandom_range(0, 99) < 10);
            mem_req_mem    = ($urandom_range(0, 99) < 30);
            mem_ready      = ($urandom_range(0, 99) < 60);
            cycle(0, '0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
